ir_slot_writer: RTL and testbench

//  Writer side of the instruction-register slot array: accepts a byte stream over valid/ready
//  and writes consecutive bytes into a DEPTH-entry slot array (slot 0 first).

---
 rtl/ir_slot_writer.sv | 101 ++++++++++
 tb/tb_ir_slot_writer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ir_slot_writer.sv
// Writer side of the IR slot array: packs a valid/ready byte stream into DEPTH slots and holds the full frame.
// Optional macro IR_BYTE_PARITY_EN adds odd-parity checking on each incoming byte.
module ir_slot_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
`ifdef IR_BYTE_PARITY_EN
  input  logic                  in_parity,
  output logic                  parity_err,
`endif
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  frame_take,
  output logic [DATA_WIDTH-1:0] slots_out [0:DEPTH-1],
  output logic [DEPTH-1:0]      slot_valid,
  output logic [IDX_W-1:0]      wr_index,
  output logic                  frame_valid
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_slots [0:DEPTH-1];
  logic [DEPTH-1:0]      r_slot_valid;
  logic [IDX_W-1:0]      r_wr_index;
  logic                  w_par_ok;
  logic                  w_wr;

`ifdef IR_BYTE_PARITY_EN
  logic r_parity_err;
  logic w_bad_xfer;

  // Odd parity: data bits plus the parity bit must hold an odd number of ones.
  assign w_par_ok   = ^{in_data, in_parity};
  assign w_bad_xfer = (r_state == FILL) & in_valid & ~flush & ~w_par_ok;
  assign parity_err = r_parity_err;

  always_ff @(posedge clk) begin
    if (!rst_n) r_parity_err <= 1'b0;
    else        r_parity_err <= w_bad_xfer;
  end
`else
  assign w_par_ok = 1'b1;
`endif

  // flush discards any same-cycle transfer.
  assign w_wr = (r_state == FILL) & in_valid & ~flush & w_par_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    frame_valid = 1'b0;
    case (r_state)
      FILL: begin
        in_ready = 1'b1;
        if (w_wr && (r_wr_index == IDX_W'(DEPTH - 1))) w_state_nxt = HOLD;
      end
      HOLD: begin
        frame_valid = 1'b1;
        if (frame_take) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
    if (flush) w_state_nxt = FILL;
  end

  // Slot data survives flush and frame_take; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_slots[i] <= '0;
      r_slot_valid <= '0;
      r_wr_index   <= '0;
    end else if (flush) begin
      r_slot_valid <= '0;
      r_wr_index   <= '0;
    end else if ((r_state == HOLD) && frame_take) begin
      r_slot_valid <= '0;
      r_wr_index   <= '0;
    end else if (w_wr) begin
      r_slots[r_wr_index]      <= in_data;
      r_slot_valid[r_wr_index] <= 1'b1;
      r_wr_index               <= r_wr_index + IDX_W'(1);
    end
  end

  assign slots_out  = r_slots;
  assign slot_valid = r_slot_valid;
  assign wr_index   = r_wr_index;

endmodule

// File: tb/tb_ir_slot_writer.sv
// Self-checking bench for ir_slot_writer: directed steps then random traffic against a frame-count model.
module tb_ir_slot_writer;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_parity;
  logic          in_ready;
  logic          flush;
  logic          frame_take;
  logic [DW-1:0] slots_out [0:DEPTH-1];
  logic [DEPTH-1:0] slot_valid;
  logic [1:0]    wr_index;
  logic          frame_valid;
  logic          parity_err;

  int n_vec = 0;
  int n_miss = 0;

  // Reference model: number of bytes held in the current frame plus the stored bytes.
  int           m_cnt;
  logic [DW-1:0] m_slot [DEPTH];
  bit           m_perr;

  ir_slot_writer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
`ifdef IR_BYTE_PARITY_EN
    .in_parity(in_parity), .parity_err(parity_err),
`endif
    .in_ready(in_ready), .flush(flush), .frame_take(frame_take),
    .slots_out(slots_out), .slot_valid(slot_valid), .wr_index(wr_index),
    .frame_valid(frame_valid)
  );

`ifndef IR_BYTE_PARITY_EN
  initial parity_err = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_edge();
    bit held, bad, accept;
    held = (m_cnt == DEPTH);
    if (!rst_n) begin
      m_cnt = 0; m_perr = 0;
      for (int i = 0; i < DEPTH; i++) m_slot[i] = '0;
      return;
    end
`ifdef IR_BYTE_PARITY_EN
    bad = ((($countones(in_data) + int'(in_parity)) % 2) == 0);
`else
    bad = 0;
`endif
    accept = in_valid && !held && !flush;
    m_perr = accept && bad;
    if (flush) m_cnt = 0;
    else if (held) begin
      if (frame_take) m_cnt = 0;
    end else if (accept && !bad) begin
      m_slot[m_cnt] = in_data;
      m_cnt++;
    end
  endfunction

  task automatic check_all();
    bit held;
    held = (m_cnt == DEPTH);
    chk("in_ready", in_ready, !held);
    chk("frame_valid", frame_valid, held);
    chk("wr_index", wr_index, m_cnt % DEPTH);
    chk("slot_valid", slot_valid, (1 << m_cnt) - 1);
    for (int i = 0; i < DEPTH; i++) chk($sformatf("slot%0d", i), slots_out[i], m_slot[i]);
`ifdef IR_BYTE_PARITY_EN
    chk("parity_err", parity_err, m_perr);
`endif
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit fl = 0,
                      input bit ft = 0, input bit rst = 1);
    in_valid = v; in_data = d; flush = fl; frame_take = ft; rst_n = rst;
    in_parity = ~^d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic [DW-1:0] bytes1 [4];
    bit gap [7];
    int k;
    bytes1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    gap = '{1, 0, 0, 1, 1, 0, 1};
    in_valid = 0; in_data = 0; flush = 0; frame_take = 0; rst_n = 0; in_parity = 1;
    #2;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // 1: fill four consecutive bytes.
    for (int i = 0; i < 4; i++) step(1, bytes1[i]);
    chk("t1_frame_valid", frame_valid, 1'b1);
    chk("t1_in_ready", in_ready, 1'b0);
    chk("t1_slot3", slots_out[3], 8'h44);
    chk("t1_slot0", slots_out[0], 8'h11);
    chk("t1_slot_valid", slot_valid, 4'b1111);

    // 2: input ignored while held, then take.
    for (int i = 0; i < 3; i++) step(1, 8'h55);
    chk("t2_slot0_kept", slots_out[0], 8'h11);
    step(0, 0, 0, 1);
    chk("t2_frame_valid", frame_valid, 1'b0);
    chk("t2_wr_index", wr_index, 2'd0);
    chk("t2_in_ready", in_ready, 1'b1);

    // 3: flush beats a same-cycle write.
    step(1, 8'hA0); step(1, 8'hA1);
    step(1, 8'hA2, 1);
    chk("t3_wr_index", wr_index, 2'd0);
    chk("t3_slot_valid", slot_valid, 4'b0000);
    chk("t3_slot2_unwritten", slots_out[2], 8'h33);
    for (int i = 0; i < 4; i++) step(1, 8'hB0 + DW'(i));
    chk("t3_slot2", slots_out[2], 8'hB2);
    step(0, 0, 0, 1);

    // 4: gapped valid.
    k = 1;
    for (int i = 0; i < 7; i++) begin
      step(gap[i], DW'(k));
      if (gap[i]) k++;
    end
    chk("t4_slot3", slots_out[3], 8'h04);
    chk("t4_frame_valid", frame_valid, 1'b1);

    // 5: reset while held.
    step(0, 0, 0, 0, 0);
    chk("t5_slot0", slots_out[0], 8'h00);
    chk("t5_frame_valid", frame_valid, 1'b0);
    step(1, 8'hC0);
    chk("t5_slot0_new", slots_out[0], 8'hC0);
    step(0, 0, 1);

`ifdef IR_BYTE_PARITY_EN
    // 6: bad parity consumed but not written.
    in_valid = 1; in_data = 8'h07; in_parity = 1; flush = 0; frame_take = 0; rst_n = 1;
    @(posedge clk); model_edge(); #1; check_all();
    chk("t6_parity_err", parity_err, 1'b1);
    chk("t6_wr_index", wr_index, 2'd0);
    step(1, 8'h07);
    chk("t6_written", slots_out[0], 8'h07);
    chk("t6_parity_clear", parity_err, 1'b0);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = DW'($urandom);
      flush      = ($urandom_range(0, 15) == 0);
      frame_take = ($urandom_range(0, 2) == 0);
      rst_n      = ($urandom_range(0, 63) != 0);
      in_parity  = ~^in_data ^ ($urandom_range(0, 4) == 0);
      @(posedge clk);
      model_edge();
      #1;
      check_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
